// File: rtl/iob_timer_alarm_pkg.sv
// Shared definitions for the timer compare/alarm unit.
// Contents: register word addresses, CTRL/STATUS bit indices, the CTRL
// register layout and the FSM state encoding.
package iob_timer_alarm_pkg;

    localparam logic [2:0] ADDR_CTRL      = 3'd0;
    localparam logic [2:0] ADDR_CMP_HI    = 3'd1;
    localparam logic [2:0] ADDR_CMP_LO    = 3'd2;
    localparam logic [2:0] ADDR_PER_HI    = 3'd3;
    localparam logic [2:0] ADDR_PER_LO    = 3'd4;
    localparam logic [2:0] ADDR_STATUS    = 3'd5;
    localparam logic [2:0] ADDR_CMP_RD    = 3'd6;
    localparam logic [2:0] ADDR_CMP_RD_HI = 3'd7;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_PER    = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int ST_PENDING  = 0;
    localparam int ST_ARMED    = 1;
    localparam int ST_OVERRUN  = 2;

    // Bit 0 = enable, so the struct maps directly onto CTRL[2:0].
    typedef struct packed {
        logic irq_en;
        logic periodic;
        logic enable;
    } ctrl_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ARMED = 1'b1
    } state_e;

endpackage

// File: rtl/iob_timer_alarm_if.sv
// CPU peripheral bus (valid/ready, word addressed) for the alarm unit.
// master: CPU side drives valid/wr/addr/data_in.
// slave : peripheral side returns registered data_out/ready.
interface iob_timer_alarm_if;
    logic        valid;
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ready;

    modport master (output valid, wr, addr, data_in, input data_out, ready);
    modport slave  (input valid, wr, addr, data_in, output data_out, ready);
endinterface

// File: rtl/iob_timer_alarm_regs.sv
// Bus decode and register file for the alarm unit.
// Holds CTRL, the CMP/PER staging registers and the committed period,
// produces one-cycle command pulses for the FSM, and registers read
// data and ready one cycle after every valid.
// Ports: clk/rst; bus (slave); compare/pending/armed/overrun (read-back);
//        ctrl, period (to FSM); cmp_lo_wr/cmp_wdata, arm_req/disarm_req,
//        clr_pending/clr_overrun (command pulses).
module iob_timer_alarm_regs
    import iob_timer_alarm_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    iob_timer_alarm_if.slave        bus,
    input  logic [63:0]             compare,
    input  logic                    pending,
    input  logic                    armed,
    input  logic                    overrun,
    output ctrl_t                   ctrl,
    output logic [63:0]             period,
    output logic                    cmp_lo_wr,
    output logic [63:0]             cmp_wdata,
    output logic                    arm_req,
    output logic                    disarm_req,
    output logic                    clr_pending,
    output logic                    clr_overrun
);

    ctrl_t       ctrl_q, ctrl_d;
    logic [31:0] cmp_stage_q, cmp_stage_d;
    logic [31:0] per_stage_q, per_stage_d;
    logic [63:0] period_q, period_d;
    logic        ready_q, ready_d;
    logic [31:0] data_out_q, data_out_d;
    logic        wen, ren;

    assign wen = bus.valid & bus.wr;
    assign ren = bus.valid & ~bus.wr;

    always_comb begin
        ctrl_d      = ctrl_q;
        cmp_stage_d = cmp_stage_q;
        per_stage_d = per_stage_q;
        period_d    = period_q;
        ready_d     = bus.valid;
        data_out_d  = data_out_q;
        cmp_lo_wr   = 1'b0;
        arm_req     = 1'b0;
        disarm_req  = 1'b0;
        clr_pending = 1'b0;
        clr_overrun = 1'b0;
        // The 64-bit compare is committed as a whole on the LO write.
        cmp_wdata   = {cmp_stage_q, bus.data_in};

        if (wen) begin
            case (bus.addr)
                ADDR_CTRL: begin
                    ctrl_d     = ctrl_t'(bus.data_in[2:0]);
                    arm_req    = bus.data_in[CTRL_EN];
                    disarm_req = ~bus.data_in[CTRL_EN];
                end
                ADDR_CMP_HI: cmp_stage_d = bus.data_in;
                ADDR_CMP_LO: begin
                    cmp_lo_wr = 1'b1;
                    arm_req   = ctrl_q.enable;
                end
                ADDR_PER_HI: per_stage_d = bus.data_in;
                ADDR_PER_LO: period_d    = {per_stage_q, bus.data_in};
                ADDR_STATUS: begin
                    clr_pending = bus.data_in[ST_PENDING];
                    clr_overrun = bus.data_in[ST_OVERRUN];
                end
                default: ;
            endcase
        end

        // data_out only moves on reads; writes leave the last read value.
        if (ren) begin
            case (bus.addr)
                ADDR_CTRL:      data_out_d = {29'd0, ctrl_q};
                ADDR_STATUS:    data_out_d = {29'd0, overrun, armed, pending};
                ADDR_CMP_RD:    data_out_d = compare[31:0];
                ADDR_CMP_RD_HI: data_out_d = compare[63:32];
                default:        data_out_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q      <= '0;
            cmp_stage_q <= '0;
            per_stage_q <= '0;
            period_q    <= '0;
            ready_q     <= 1'b0;
            data_out_q  <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            cmp_stage_q <= cmp_stage_d;
            per_stage_q <= per_stage_d;
            period_q    <= period_d;
            ready_q     <= ready_d;
            data_out_q  <= data_out_d;
        end
    end

    assign ctrl         = ctrl_q;
    assign period       = period_q;
    assign bus.ready    = ready_q;
    assign bus.data_out = data_out_q;

endmodule

// File: rtl/iob_timer_alarm.sv
// Compare/alarm unit fed by the free-running 64-bit cycle timer.
// Fires when counter >= compare while armed; sets sticky pending (and
// overrun if pending was already set), optionally reloads compare by the
// period. irq = pending & irq_en, registered.
// Ports: clk, rst (async, active-high); counter (live timer value);
//        bus (slave register port); irq.
module iob_timer_alarm
    import iob_timer_alarm_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [63:0]         counter,
    iob_timer_alarm_if.slave    bus,
    output logic                irq
);

    state_e      state_q, state_d;
    logic [63:0] counter_q, counter_d;
    logic [63:0] compare_q, compare_d;
    logic        pending_q, pending_d;
    logic        overrun_q, overrun_d;
    logic        irq_q, irq_d;
    logic        fire;

    ctrl_t       ctrl;
    logic [63:0] period;
    logic        cmp_lo_wr;
    logic [63:0] cmp_wdata;
    logic        arm_req, disarm_req, clr_pending, clr_overrun;

    iob_timer_alarm_regs u_regs (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .compare     (compare_q),
        .pending     (pending_q),
        .armed       (state_q == S_ARMED),
        .overrun     (overrun_q),
        .ctrl        (ctrl),
        .period      (period),
        .cmp_lo_wr   (cmp_lo_wr),
        .cmp_wdata   (cmp_wdata),
        .arm_req     (arm_req),
        .disarm_req  (disarm_req),
        .clr_pending (clr_pending),
        .clr_overrun (clr_overrun)
    );

    // Counter is registered first, so a match seen at edge N lands in
    // pending at N+1. A CMP_LO write in the same cycle suppresses the fire.
    assign fire = (state_q == S_ARMED) && (counter_q >= compare_q) && !cmp_lo_wr;

    always_comb begin
        state_d   = state_q;
        counter_d = counter;
        compare_d = compare_q;
        pending_d = pending_q & ~clr_pending;
        overrun_d = overrun_q & ~clr_overrun;
        irq_d     = pending_q & ctrl.irq_en;

        // Set beats a same-cycle W1C.
        if (fire) begin
            pending_d = 1'b1;
            if (pending_q)
                overrun_d = 1'b1;
            if (ctrl.periodic && (period != 64'd0))
                compare_d = compare_q + period;
            else
                state_d = S_IDLE;
        end

        if (cmp_lo_wr)
            compare_d = cmp_wdata;

        // Bus commands override the fire's state change.
        if (disarm_req)
            state_d = S_IDLE;
        else if (arm_req)
            state_d = S_ARMED;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            counter_q <= '0;
            compare_q <= '1;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            compare_q <= compare_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            irq_q     <= irq_d;
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_iob_timer_alarm.sv
// Scoreboard bench for iob_timer_alarm: the driver pushes the expected
// post-edge outputs from a behavioural model; a monitor pops and compares.
module tb_iob_timer_alarm;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] counter;
    logic        irq;

    iob_timer_alarm_if bus_if ();

    iob_timer_alarm dut (
        .clk     (clk),
        .rst     (rst),
        .counter (counter),
        .bus     (bus_if),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        irq;
        logic        rdy;
        logic [31:0] dout;
    } exp_t;

    exp_t expq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Behavioural model state
    bit          m_en, m_per, m_ie, m_pend, m_ovr, m_armed;
    logic [63:0] m_cmp, m_period, m_cnt_s;
    logic [31:0] m_cs, m_ps, m_dout;

    logic [63:0] cnt;
    logic [63:0] ramp;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void m_reset();
        m_en = 0; m_per = 0; m_ie = 0; m_pend = 0; m_ovr = 0; m_armed = 0;
        m_cmp = '1; m_period = 0; m_cnt_s = 0;
        m_cs = 0; m_ps = 0; m_dout = 0;
    endfunction

    function automatic logic [31:0] m_read(logic [2:0] a);
        case (a)
            3'd0:    return {29'd0, m_ie, m_per, m_en};
            3'd5:    return {29'd0, m_ovr, m_armed, m_pend};
            3'd6:    return m_cmp[31:0];
            3'd7:    return m_cmp[63:32];
            default: return 32'd0;
        endcase
    endfunction

    // One bus cycle: drive at negedge, advance the model to the state after
    // the coming posedge, queue what the outputs must then show.
    task automatic step(input bit v, input bit w, input logic [2:0] a, input logic [31:0] d);
        exp_t e;
        bit   old_pend, old_en, fire, cmp_lo;
        @(negedge clk);
        bus_if.valid   = v;
        bus_if.wr      = w;
        bus_if.addr    = a;
        bus_if.data_in = d;
        counter        = cnt;

        old_pend = m_pend;
        old_en   = m_en;
        e.irq    = m_pend & m_ie;
        e.rdy    = v;
        if (v && !w) m_dout = m_read(a);
        e.dout   = m_dout;

        cmp_lo = v && w && (a == 3'd2);
        fire   = m_armed && (m_cnt_s >= m_cmp) && !cmp_lo;
        m_cnt_s = cnt;

        if (v && w && a == 3'd5) begin
            if (d[0]) m_pend = 0;
            if (d[2]) m_ovr  = 0;
        end
        if (fire) begin
            if (old_pend) m_ovr = 1;
            m_pend = 1;
            if (m_per && m_period != 0) m_cmp = m_cmp + m_period;
            else m_armed = 0;
        end
        if (v && w) begin
            case (a)
                3'd0: begin m_en = d[0]; m_per = d[1]; m_ie = d[2]; m_armed = d[0]; end
                3'd1: m_cs = d;
                3'd2: begin m_cmp = {m_cs, d}; if (old_en) m_armed = 1; end
                3'd3: m_ps = d;
                3'd4: m_period = {m_ps, d};
                default: ;
            endcase
        end
        expq.push_back(e);
        cnt = cnt + ramp;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        step(1, 1, a, d);
    endtask

    task automatic rd(input logic [2:0] a);
        step(1, 0, a, 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 3'd0, 32'd0);
    endtask

    task automatic rst_pulse();
        exp_t e;
        @(negedge clk);
        bus_if.valid = 0;
        #2 rst = 1;
        #1;
        chk("rst_irq", 64'(irq), 64'd0);
        chk("rst_ready", 64'(bus_if.ready), 64'd0);
        chk("rst_data_out", 64'(bus_if.data_out), 64'd0);
        m_reset();
        m_cnt_s = counter;
        e.irq = 0; e.rdy = 0; e.dout = 0;
        expq.push_back(e);
        @(negedge clk);
        rst = 0;
    endtask

    // Monitor: compares whatever the driver queued for this edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("irq", 64'(irq), 64'(e.irq));
                chk("ready", 64'(bus_if.ready), 64'(e.rdy));
                chk("data_out", 64'(bus_if.data_out), 64'(e.dout));
            end
        end
    end

    initial begin : driver
        logic [31:0] dv;
        int r;
        rst = 1;
        bus_if.valid = 0; bus_if.wr = 0; bus_if.addr = 0; bus_if.data_in = 0;
        counter = 0; cnt = 0; ramp = 0;
        m_reset();
        repeat (2) @(negedge clk);
        chk("reset_irq", 64'(irq), 64'd0);
        chk("reset_ready", 64'(bus_if.ready), 64'd0);
        chk("reset_data_out", 64'(bus_if.data_out), 64'd0);
        rst = 0;

        // Reset register values
        rd(3'd5); rd(3'd7); rd(3'd6); rd(3'd0); rd(3'd1);

        // One-shot at 100
        wr(3'd0, 32'h5); wr(3'd1, 0); wr(3'd2, 100);
        cnt = 95; ramp = 1;
        idle(10);
        rd(3'd5);
        wr(3'd5, 32'h1);
        idle(3);
        rd(3'd5);

        // Periodic 100/150/200, pending left set -> overrun
        ramp = 0; cnt = 0;
        wr(3'd0, 32'h7); wr(3'd3, 0); wr(3'd4, 50); wr(3'd1, 0); wr(3'd2, 100);
        cnt = 98; ramp = 1;
        idle(5);
        rd(3'd6); rd(3'd7);
        idle(50);
        rd(3'd5);
        wr(3'd5, 32'h5);
        idle(60);
        rd(3'd5); rd(3'd6);
        wr(3'd0, 32'h0);
        rd(3'd5);

        // 64-bit compare across the 32-bit boundary
        ramp = 0;
        wr(3'd5, 32'h7);
        wr(3'd1, 1); wr(3'd2, 0); wr(3'd0, 32'h5);
        cnt = 64'hFFFF_FFFD; ramp = 1;
        idle(6);
        rd(3'd5);
        wr(3'd5, 32'h7);

        // Counter drops to 0 while armed at 500
        ramp = 0; cnt = 100;
        wr(3'd1, 0); wr(3'd2, 500);
        cnt = 0; ramp = 1;
        idle(10);
        rd(3'd5);
        cnt = 495;
        idle(10);
        rd(3'd5);
        wr(3'd5, 32'h7);

        // Periodic catch-up with W1C and CMP_LO collisions
        ramp = 0; cnt = 5000;
        wr(3'd0, 32'h7); wr(3'd2, 4000);
        idle(3);
        wr(3'd5, 32'h1); wr(3'd5, 32'h5);
        idle(2);
        wr(3'd2, 6000);
        rd(3'd5); rd(3'd6);
        idle(3);
        rd(3'd5);

        // Async reset during a periodic run
        wr(3'd5, 32'h7);
        wr(3'd2, 5010); ramp = 1;
        idle(12);
        rst_pulse();
        idle(20);
        rd(3'd5); rd(3'd7); rd(3'd0);

        // Randomised traffic
        cnt = 64'd1000; ramp = 0;
        for (int i = 0; i < 2000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) cnt = 0;
            else if (r < 3) cnt = 64'hFFFF_FFF0;
            else cnt = cnt + 64'($urandom_range(0, 3));
            r = int'($urandom_range(0, 99));
            if (r < 40) begin
                idle(1);
            end else if (r < 55) begin
                rd(3'($urandom_range(0, 7)));
            end else begin
                case ($urandom_range(0, 5))
                    0: begin
                        dv = $urandom_range(0, 7);
                        if ($urandom_range(0, 9) == 0) dv = $urandom;
                        wr(3'd0, dv);
                    end
                    1: wr(3'd1, cnt[63:32] + 32'($urandom_range(0, 1)));
                    2: wr(3'd2, cnt[31:0] + 32'($urandom_range(0, 30)));
                    3: wr(3'd3, ($urandom_range(0, 15) == 0) ? 32'd1 : 32'd0);
                    4: wr(3'd4, 32'($urandom_range(0, 40)));
                    default: wr(3'd5, 32'($urandom_range(0, 7)));
                endcase
            end
            if ($urandom_range(0, 499) == 0) rst_pulse();
        end

        idle(3);
        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
